// File: rtl/flash_pattern_tester.sv
// Flash self-test sequencer: erase, blank check, pattern program and pattern verify
// over a word-address window, issued through a request/done command port.
module flash_pattern_tester #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TMO_W  = 24,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              iCLK_28,
    input  logic              iRESET,
    input  logic              iSTART,
    input  logic [1:0]        iMODE,
    input  logic              iSKIP_ERASE,
    input  logic [ADDR_W-1:0] iADDR_LO,
    input  logic [ADDR_W-1:0] iADDR_HI,
    output logic              oFL_REQ,
    output logic [3:0]        oFL_CMD,
    output logic [ADDR_W-1:0] oFL_ADDR,
    output logic [DATA_W-1:0] oFL_WDATA,
    input  logic              iFL_DONE,
    input  logic [DATA_W-1:0] iFL_RDATA,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oPASS,
    output logic              oFAIL,
    output logic              oTIMEOUT,
    output logic [2:0]        oPHASE,
    output logic [ERR_W-1:0]  oERR_CNT,
    output logic [ADDR_W-1:0] oERR_ADDR,
    output logic [DATA_W-1:0] oERR_DATA
);

    localparam int unsigned LOG_D = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERASE  = 3'd1;
    localparam logic [2:0] S_BLANK  = 3'd2;
    localparam logic [2:0] S_PROG   = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_END    = 3'd5;

    localparam logic [3:0] CMD_PROG  = 4'h1;
    localparam logic [3:0] CMD_READ  = 4'h2;
    localparam logic [3:0] CMD_ERASE = 4'h4;

    localparam logic [TMO_W-1:0] TMO_ALL  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_ALL - TMO_W'(1);

    // Expected word for a given address under the selected pattern
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode,
                                                  input logic [ADDR_W-1:0] addr);
        case (mode)
            2'd0:    pattern = DATA_W'(addr);
            2'd1:    pattern = addr[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
            2'd2:    pattern = '0;
            default: pattern = DATA_W'(1) << addr[LOG_D-1:0];
        endcase
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
    logic [1:0]        mode_q, mode_d;
    logic              bad_range_q, bad_range_d;
    logic              req_q, req_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;

    logic [DATA_W-1:0] exp_c;
    logic              mismatch_c;
    logic              last_c;

    // Read compare: blank check expects erased ones, verify expects the pattern
    always_comb begin
        exp_c      = (state_q == S_BLANK) ? {DATA_W{1'b1}} : pattern(mode_q, addr_q);
        mismatch_c = ((state_q == S_BLANK) || (state_q == S_VERIFY)) && (iFL_RDATA != exp_c);
        last_c     = (ptr_q == hi_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        bad_range_d = bad_range_q;
        req_d       = req_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    err_cnt_d   = '0;
                    err_addr_d  = '0;
                    err_data_d  = '0;
                    lo_d        = iADDR_LO;
                    hi_d        = iADDR_HI;
                    mode_d      = iMODE;
                    ptr_d       = iADDR_LO;
                    bad_range_d = (iADDR_HI < iADDR_LO);
                    if (iADDR_HI < iADDR_LO) begin
                        state_d = S_END;
                    end else if (iSKIP_ERASE) begin
                        state_d = S_PROG;
                    end else begin
                        state_d = S_ERASE;
                    end
                end
            end

            S_ERASE, S_BLANK, S_PROG, S_VERIFY: begin
                if (!req_q) begin
                    // One idle cycle after each command, then issue the next
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    addr_d  = ptr_q;
                    wdata_d = '0;
                    case (state_q)
                        S_ERASE: cmd_d = CMD_ERASE;
                        S_PROG: begin
                            cmd_d   = CMD_PROG;
                            wdata_d = pattern(mode_q, ptr_q);
                        end
                        default: cmd_d = CMD_READ;
                    endcase
                end else if (iFL_DONE) begin
                    req_d = 1'b0;
                    if (mismatch_c) begin
                        if (err_cnt_q == '0) begin
                            err_addr_d = addr_q;
                            err_data_d = iFL_RDATA;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                    if (state_q == S_ERASE) begin
                        state_d = S_BLANK;
                    end else if (last_c) begin
                        // Equality stop so an all-ones HI never relies on wrap
                        ptr_d = lo_q;
                        case (state_q)
                            S_BLANK: state_d = S_PROG;
                            S_PROG:  state_d = S_VERIFY;
                            default: state_d = S_END;
                        endcase
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    pass_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_END: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == '0) && !bad_range_q;
                fail_d  = !((err_cnt_q == '0) && !bad_range_q);
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLK_28) begin
        if (iRESET) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            ptr_q       <= '0;
            mode_q      <= '0;
            bad_range_q <= 1'b0;
            req_q       <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
            bad_range_q <= bad_range_d;
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
        end
    end

    assign oFL_REQ   = req_q;
    assign oFL_CMD   = cmd_q;
    assign oFL_ADDR  = addr_q;
    assign oFL_WDATA = wdata_q;
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oPASS     = pass_q;
    assign oFAIL     = fail_q;
    assign oTIMEOUT  = timeout_q;
    assign oPHASE    = state_q;
    assign oERR_CNT  = err_cnt_q;
    assign oERR_ADDR = err_addr_q;
    assign oERR_DATA = err_data_q;

endmodule

// File: tb/tb_flash_pattern_tester.sv
// Randomised bench for flash_pattern_tester: a flash controller model plus a
// reference that derives the expected command stream and results from the window.
module tb_flash_pattern_tester;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned ERR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic              skip;
    logic [ADDR_W-1:0] addr_lo, addr_hi;
    logic              fl_req;
    logic [3:0]        fl_cmd;
    logic [ADDR_W-1:0] fl_addr;
    logic [DATA_W-1:0] fl_wdata;
    logic              fl_done;
    logic [DATA_W-1:0] fl_rdata;
    logic              busy, done, pass, fail, tmo;
    logic [2:0]        phase;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    always #5 clk = ~clk;

    flash_pattern_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W), .ERR_W(ERR_W)
    ) dut (
        .iCLK_28(clk), .iRESET(rst), .iSTART(start), .iMODE(mode),
        .iSKIP_ERASE(skip), .iADDR_LO(addr_lo), .iADDR_HI(addr_hi),
        .oFL_REQ(fl_req), .oFL_CMD(fl_cmd), .oFL_ADDR(fl_addr), .oFL_WDATA(fl_wdata),
        .iFL_DONE(fl_done), .iFL_RDATA(fl_rdata),
        .oBUSY(busy), .oDONE(done), .oPASS(pass), .oFAIL(fail), .oTIMEOUT(tmo),
        .oPHASE(phase), .oERR_CNT(err_cnt), .oERR_ADDR(err_addr), .oERR_DATA(err_data)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents and fault injection knobs
    logic [15:0] mem [256];
    bit          progd [256];
    bit          hang = 0;
    bit          zero_all = 0;
    bit          corrupt_en = 0;
    int          corrupt_addr = 0;
    logic [15:0] corrupt_val = '0;

    // Command log entries: {cmd, addr, program data (0 for non-program)}
    logic [35:0] log_q [$];
    logic [35:0] exp_q [$];
    int          exp_nerr;
    logic [15:0] exp_eaddr, exp_edata;

    bit          prev_req = 0;
    bit          have_cmd = 0;
    int          proto_errs = 0;
    int          low_run = 0;
    int          req_run = 0;
    int          last_req_run = 0;
    int          wait_cnt = 0;
    logic [35:0] cap;

    function automatic logic [15:0] read_value(input int a, input logic [15:0] stored,
                                               input bit programmed);
        if (zero_all) return 16'h0000;
        if (corrupt_en && programmed && a == corrupt_addr) return corrupt_val;
        return stored;
    endfunction

    function automatic logic [15:0] pat(input int m, input int a);
        case (m)
            0:       return 16'(a % 65536);
            1:       return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
            2:       return 16'h0000;
            default: return 16'(1 << (a % 16));
        endcase
    endfunction

    function automatic logic [35:0] entry(input int c, input int a, input logic [15:0] d);
        return {4'(c), 16'(a), d};
    endfunction

    // Flash controller model and request-protocol monitor
    initial begin : flash_ctl
        fl_done  = 1'b0;
        fl_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'($urandom);
            progd[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            fl_done = 1'b0;
            if (fl_req) begin
                if (!prev_req) begin
                    if (have_cmd && low_run != 1) proto_errs++;
                    cap     = {fl_cmd, 16'(fl_addr), fl_wdata};
                    req_run = 1;
                end else begin
                    req_run++;
                    if ({fl_cmd, 16'(fl_addr), fl_wdata} != cap) proto_errs++;
                end
            end else begin
                if (prev_req) begin
                    last_req_run = req_run;
                    low_run      = 1;
                end else begin
                    low_run++;
                end
            end
            prev_req = fl_req;
            if (fl_req && !hang) begin
                if (wait_cnt == 0) begin
                    case (fl_cmd)
                        4'h4: for (int i = 0; i < 256; i++) begin
                            mem[i]   = 16'hFFFF;
                            progd[i] = 0;
                        end
                        4'h1: begin
                            mem[fl_addr]   = fl_wdata;
                            progd[fl_addr] = 1;
                        end
                        default: fl_rdata = read_value(int'(fl_addr), mem[fl_addr], progd[fl_addr]);
                    endcase
                    log_q.push_back(entry(int'(fl_cmd), int'(fl_addr),
                                          (fl_cmd == 4'h1) ? fl_wdata : 16'h0000));
                    fl_done  = 1'b1;
                    have_cmd = 1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if (!fl_req && $urandom_range(0, 7) == 0) begin
                fl_done = 1'b1;  // stray pulse with no request outstanding
            end
        end
    end

    task automatic note_err(input int a, input logic [15:0] v);
        if (exp_nerr == 0) begin
            exp_eaddr = 16'(a);
            exp_edata = v;
        end
        exp_nerr++;
    endtask

    // Reference: walk the phases over a copy of the flash contents
    task automatic build_expect(input int lo, input int hi, input int m, input bit sk);
        logic [15:0] mem_s [256];
        bit          progd_s [256];
        logic [15:0] v;
        mem_s   = mem;
        progd_s = progd;
        exp_q.delete();
        exp_nerr  = 0;
        exp_eaddr = '0;
        exp_edata = '0;
        if (hi < lo) return;
        if (!sk) begin
            exp_q.push_back(entry(4, lo, 16'h0));
            for (int i = 0; i < 256; i++) begin
                mem_s[i]   = 16'hFFFF;
                progd_s[i] = 0;
            end
            for (int a = lo; a <= hi; a++) begin
                exp_q.push_back(entry(2, a, 16'h0));
                v = read_value(a, mem_s[a], progd_s[a]);
                if (v != 16'hFFFF) note_err(a, v);
            end
        end
        for (int a = lo; a <= hi; a++) begin
            exp_q.push_back(entry(1, a, pat(m, a)));
            mem_s[a]   = pat(m, a);
            progd_s[a] = 1;
        end
        for (int a = lo; a <= hi; a++) begin
            exp_q.push_back(entry(2, a, 16'h0));
            v = read_value(a, mem_s[a], progd_s[a]);
            if (v != pat(m, a)) note_err(a, v);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({fl_req, fl_cmd, fl_addr, fl_wdata, busy, done, pass, fail, tmo,
                    phase, err_cnt, err_addr, err_data});
    endfunction

    task automatic run_seq(input int lo, input int hi, input int m, input bit sk,
                           input bit expect_tmo);
        int k;
        int n;
        bit ok;
        if (!expect_tmo) build_expect(lo, hi, m, sk);
        else exp_q.delete();
        @(negedge clk);
        log_q.delete();
        have_cmd   = 0;
        proto_errs = 0;
        addr_lo    = ADDR_W'(lo);
        addr_hi    = ADDR_W'(hi);
        mode       = 2'(m);
        skip       = sk;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", 64'(busy), 64'd1);
        k = 1;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        ok = done;
        check_eq("done_seen", 64'(done), 64'd1);
        if (ok) begin
            if (expect_tmo) begin
                check_eq("tmo_flag", 64'(tmo), 64'd1);
                check_eq("tmo_fail", 64'(fail), 64'd1);
                check_eq("tmo_pass", 64'(pass), 64'd0);
                check_eq("tmo_req_low", 64'(fl_req), 64'd0);
                check_eq("tmo_req_cycles", 64'(last_req_run), 64'((1 << TMO_W) - 1));
            end else begin
                check_eq("pass", 64'(pass), 64'(hi >= lo && exp_nerr == 0));
                check_eq("fail", 64'(fail), 64'(!(hi >= lo && exp_nerr == 0)));
                check_eq("timeout", 64'(tmo), 64'd0);
                check_eq("err_cnt", 64'(err_cnt), 64'((exp_nerr > 3) ? 3 : exp_nerr));
                check_eq("err_addr", 64'(err_addr), 64'(exp_eaddr));
                check_eq("err_data", 64'(err_data), 64'(exp_edata));
                if (hi < lo) check_eq("bad_range_latency", 64'(k), 64'd2);
            end
            check_eq("busy_fall", 64'(busy), 64'd0);
            @(negedge clk);
            check_eq("done_single", 64'(done), 64'd0);
            check_eq("phase_idle", 64'(phase), 64'd0);
            check_eq("fail_held", 64'(fail), 64'(expect_tmo || !(hi >= lo && exp_nerr == 0)));
        end
        check_eq("proto", 64'(proto_errs), 64'd0);
        check_eq("ncmd", 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq("cmd", 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    initial begin : stim
        int lo, hi, m, waited;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = '0;
        skip    = 1'b0;
        addr_lo = '0;
        addr_hi = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_vals", all_outs(), 64'd0);

        run_seq(0, 3, 0, 0, 0);

        corrupt_en   = 1;
        corrupt_addr = 'h12;
        corrupt_val  = 16'h0000;
        run_seq('h10, 'h13, 1, 0, 0);
        check_eq("tp2_err_addr", 64'(err_addr), 64'h12);
        corrupt_en = 0;

        run_seq(0, 17, 3, 0, 0);
        run_seq('hFD, 'hFF, 0, 0, 0);

        hang = 1;
        run_seq(0, 3, 0, 0, 1);
        hang = 0;

        // Reset while programming, then a clean rerun
        @(negedge clk);
        addr_lo = 8'd0;
        addr_hi = 8'd5;
        mode    = 2'd0;
        skip    = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (phase != 3'd3 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_eq("reach_prog", 64'(phase), 64'd3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("no_req_after_rst", 64'(fl_req), 64'd0);
        run_seq(0, 5, 2, 0, 0);

        run_seq(5, 2, 1, 1, 0);

        zero_all = 1;
        run_seq(0, 5, 1, 0, 0);
        zero_all = 0;

        for (int r = 0; r < 10; r++) begin
            lo = $urandom_range(0, 255);
            if ($urandom_range(0, 5) == 0 && lo > 0) hi = $urandom_range(0, lo - 1);
            else hi = (lo + $urandom_range(0, 5) > 255) ? 255 : lo + $urandom_range(0, 5);
            m            = $urandom_range(0, 3);
            corrupt_en   = ($urandom_range(0, 1) == 1);
            corrupt_addr = lo + $urandom_range(0, 3);
            corrupt_val  = 16'($urandom);
            run_seq(lo, hi, m, ($urandom_range(0, 2) == 0), 0);
        end
        corrupt_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_pattern_tester.md
# flash_pattern_tester

Parametrised flash self-test sequencer for the board flash path. It issues chip erase, blank check, pattern program and pattern verify over a programmable word-address window through a request/done command port on the flash controller. It reports pass/fail, a saturating error count and first-failure capture, and aborts on a per-operation timeout. It replaces the fixed single-pattern word tester and adds selectable patterns, address range and blank verify.

## Interface
- ADDR_W, 22: flash word-address width.
- DATA_W, 16: flash word width; power of two, >= 4.
- TMO_W, 24: timeout counter width; an operation times out after 2^TMO_W-1 cycles.
- ERR_W, 16: error counter width; counter saturates.
- iCLK_28  in  1  system clock; all logic on rising edge.
- iRESET  in  1  synchronous, active-high reset.
- iSTART  in  1  one-cycle start pulse; ignored while oBUSY=1.
- iMODE  in  2  pattern: 0 = address, 1 = checkerboard, 2 = all-zero, 3 = walking-one.
- iSKIP_ERASE  in  1  skip the ERASE and BLANK phases; sampled on iSTART.
- iADDR_LO, iADDR_HI  in  ADDR_W each  inclusive address window; sampled on iSTART.
- oFL_REQ  out  1  command request, held until done.
- oFL_CMD  out  4  command: 4'h1 = program, 4'h2 = read, 4'h4 = chip erase.
- oFL_ADDR  out  ADDR_W  command address.
- oFL_WDATA  out  DATA_W  program data.
- iFL_DONE  in  1  one-cycle completion pulse from the controller.
- iFL_RDATA  in  DATA_W  read data; valid only in the iFL_DONE cycle of a read.
- oBUSY  out  1  sequence running.
- oDONE  out  1  one-cycle pulse at sequence end.
- oPASS, oFAIL  out  1 each  result; held until the next iSTART or reset.
- oTIMEOUT  out  1  abort cause; held like oFAIL.
- oPHASE  out  3  current state encoding (see Operation).
- oERR_CNT  out  ERR_W  mismatching words.
- oERR_ADDR, oERR_DATA  out  ADDR_W / DATA_W  address and read data of the first mismatch.

## Operation
- States and encodings: IDLE=0, ERASE=1, BLANK=2, PROG=3, VERIFY=4, END=5.
- IDLE to ERASE on iSTART. If iSKIP_ERASE=1, go directly to PROG.
- On iSTART: clear oPASS, oFAIL, oTIMEOUT, oERR_CNT, oERR_ADDR, oERR_DATA.
- Also on iSTART: latch the window and mode, and load the address pointer with iADDR_LO.
- ERASE: one command, cmd 4'h4, addr iADDR_LO. On done go to BLANK.
- BLANK: read each address LO..HI and compare against all-ones.
- PROG: program each address LO..HI with pattern(addr).
- VERIFY: read each address and compare against pattern(addr).
- After the last address of a phase (pointer == HI), reload the pointer with LO and move to the next phase.
- After the last address of VERIFY, go to END.
- END: assert oDONE for one cycle. oPASS = (oERR_CNT==0), oFAIL = !oPASS. Then return to IDLE.
- Pattern definitions:
  - address: addr[DATA_W-1:0], zero-extended when ADDR_W < DATA_W.
  - checkerboard: addr[0] ? {DATA_W/2{2'b01}} : {DATA_W/2{2'b10}}.
  - all-zero: 0.
  - walking-one: 1 << addr[log2(DATA_W)-1:0].
- Mismatch handling:
  - oERR_CNT increments by 1 per mismatch and saturates at all-ones.
  - oERR_ADDR/oERR_DATA load only when oERR_CNT==0 before the increment, i.e. first mismatch only.
- Verification continues after mismatches; only a timeout aborts.
- Timeout: the counter clears on each new request. If it reaches 2^TMO_W-1 while waiting, drop oFL_REQ, set oTIMEOUT and oFAIL, pulse oDONE, go to IDLE. oPASS=0.
- iADDR_HI < iADDR_LO: no flash commands. oDONE pulses 2 cycles after iSTART with oFAIL=1.
- Address pointer is ADDR_W wide. The HI == all-ones case must terminate on the equality compare, not on wrap.

## Timing
- Reset values: oFL_REQ=0, oFL_CMD=0, oFL_ADDR=0, oFL_WDATA=0, oBUSY=0, oDONE=0, oPASS=0, oFAIL=0, oTIMEOUT=0, oPHASE=0, oERR_CNT=0, oERR_ADDR=0, oERR_DATA=0.
- Reset mid-sequence: oFL_REQ drops at the reset edge; no further commands are issued.
- oBUSY rises the cycle after iSTART.
- oFL_REQ rises with oFL_CMD/oFL_ADDR/oFL_WDATA stable; all are held until iFL_DONE is sampled.
- oFL_REQ is low for exactly one cycle between consecutive commands.
- iFL_DONE arriving while oFL_REQ=0 is ignored.
- iFL_DONE coincident with the timeout terminal count: done wins and the operation completes normally.
- iFL_RDATA is compared in the iFL_DONE cycle. oERR_CNT updates one cycle later.
- oDONE and the final oPASS/oFAIL become valid in the same cycle. oBUSY falls in that same cycle.

## Test plan
- Window 0..3, mode 0, model stores data exactly → 1 erase, 4 blank reads, 4 programs, 4 reads; oPASS=1, oERR_CNT=0, oDONE single pulse.
- Mode 1, window 0x10..0x13, model forces read of 0x12 to 0x0000 → oERR_CNT=1, oERR_ADDR=0x12, oERR_DATA=0x0000, oFAIL=1.
- Mode 3, DATA_W=16, window 0..17 → programmed data 0x0001..0x8000, then 0x0001, 0x0002 at addresses 16 and 17; pass.
- Controller never returns iFL_DONE on erase, TMO_W=8 → oFL_REQ drops after 255 cycles; oTIMEOUT=1, oFAIL=1, oPASS=0.
- iRESET mid-PROG → next cycle all outputs at reset values; new iSTART runs the full sequence cleanly.
- iSKIP_ERASE=1 with window HI < LO → no requests issued; oDONE pulse with oFAIL=1. Model returning all-zero on every read with ERR_W=2 → oERR_CNT saturates at 3.
